ma_stage: RTL and testbench

//  Memory-access stage: consumes EX->MA pipeline regs, runs one data-memory handshake per load/store.

---
 rtl/ma_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_ma_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage with data-memory handshake and WB/WB2 registers
module ma_stage #(
  parameter int WDOG_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        rst_pipe,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  output logic        dm_req,
  output logic        dm_we,
  output logic [29:0] dm_adr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        dc_stall,
  output logic        ma_misalign,
  output logic        ma_bus_err,
  output logic [4:0]  rd_adr_wb,
  output logic [31:0] wbk_data_wb,
  output logic        wbk_rd_reg_wb,
  output logic [4:0]  rd_adr_wb2,
  output logic [31:0] wbk_data_wb2,
  output logic        wbk_rd_reg_wb2
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value seen in WAIT before the watchdog gives up (2**WDOG_W-1 WAIT cycles)
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((2 ** WDOG_W) - 2);

  state_t            r_state;
  state_t            w_next;
  logic [WDOG_W-1:0] r_wdog;
  logic              r_squash;
  logic [29:0]       r_adr;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_ld;
  logic [2:0]        r_code;
  logic [1:0]        r_lo;
  logic [31:0]       r_cap;
  logic [4:0]        r_rd_adr_wb;
  logic [31:0]       r_data_wb;
  logic              r_en_wb;
  logic [4:0]        r_rd_adr_wb2;
  logic [31:0]       r_data_wb2;
  logic              r_en_wb2;

  logic              w_is_mem;
  logic              w_misalign;
  logic              w_issue;
  logic              w_timeout;
  logic              w_squash;
  logic              w_adv;
  logic              w_drop;
  logic [2:0]        w_code;
  logic [1:0]        w_lo;
  logic              w_is_ld;
  logic [31:0]       w_ld_now;
  logic [31:0]       w_wb_data;

  // Byte/half lane select with sign or zero extension; unknown codes pass the word through
  function automatic logic [31:0] f_ld_fmt(input logic [2:0] code, input logic [1:0] lo,
                                           input logic [31:0] rdata);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    logic [31:0] v_r;
    v_b = rdata[{lo, 3'b000} +: 8];
    v_h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (code)
      3'b000:  v_r = {{24{v_b[7]}}, v_b};
      3'b001:  v_r = {{16{v_h[15]}}, v_h};
      3'b100:  v_r = {24'd0, v_b};
      3'b101:  v_r = {16'd0, v_h};
      default: v_r = rdata;
    endcase
    return v_r;
  endfunction

  function automatic logic [3:0] f_st_be(input logic [2:0] code, input logic [1:0] lo);
    logic [3:0] v_be;
    case (code[1:0])
      2'b00:   v_be = 4'b0001 << lo;
      2'b01:   v_be = lo[1] ? 4'b1100 : 4'b0011;
      default: v_be = 4'b1111;
    endcase
    return v_be;
  endfunction

  function automatic logic [31:0] f_st_data(input logic [2:0] code, input logic [31:0] data);
    logic [31:0] v_d;
    case (code[1:0])
      2'b00:   v_d = {4{data[7:0]}};
      2'b01:   v_d = {2{data[15:0]}};
      default: v_d = data;
    endcase
    return v_d;
  endfunction

  assign w_is_mem   = cmd_ld_ma | cmd_st_ma;
  assign w_misalign = w_is_mem &
                      (((ldst_code_ma[1:0] == 2'b01) & rd_data_ma[0]) |
                       (ldst_code_ma[1] & (rd_data_ma[1:0] != 2'b00)));
  // A squashed instruction must never reach the bus
  assign w_issue    = (r_state == S_IDLE) & w_is_mem & ~w_misalign & ~rst_pipe;
  assign w_timeout  = (r_state == S_WAIT) & ~dm_ack & (r_wdog == WDOG_LAST);
  assign w_squash   = r_squash | rst_pipe;

  // Formatting context comes from the live inputs on issue, from the latched copy afterwards
  assign w_code     = (r_state == S_IDLE) ? ldst_code_ma : r_code;
  assign w_lo       = (r_state == S_IDLE) ? rd_data_ma[1:0] : r_lo;
  assign w_is_ld    = (r_state == S_IDLE) ? cmd_ld_ma : r_ld;
  assign w_ld_now   = w_timeout ? 32'd0 : f_ld_fmt(w_code, w_lo, dm_rdata);
  assign w_wb_data  = ~w_is_ld ? rd_data_ma : ((r_state == S_DONE) ? r_cap : w_ld_now);

  assign dc_stall   = (w_issue & ~dm_ack) | ((r_state == S_WAIT) & ~dm_ack & ~w_timeout);
  assign w_adv      = ~stall & ~dc_stall;
  assign w_drop     = (r_state == S_WAIT) & r_squash;

  assign ma_misalign = w_misalign;
  assign ma_bus_err  = w_timeout;

  assign rd_adr_wb      = r_rd_adr_wb;
  assign wbk_data_wb    = r_data_wb;
  assign wbk_rd_reg_wb  = r_en_wb;
  assign rd_adr_wb2     = r_rd_adr_wb2;
  assign wbk_data_wb2   = r_data_wb2;
  assign wbk_rd_reg_wb2 = r_en_wb2;

  // Bus request: live values on the issue cycle, latched values while waiting, idle-zero otherwise
  always_comb begin
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_adr   = 30'd0;
    dm_be    = 4'd0;
    dm_wdata = 32'd0;
    if (r_state == S_WAIT) begin
      dm_req   = 1'b1;
      dm_we    = r_we;
      dm_adr   = r_adr;
      dm_be    = r_be;
      dm_wdata = r_wdata;
    end else if (w_issue) begin
      dm_req   = 1'b1;
      dm_we    = cmd_st_ma;
      dm_adr   = rd_data_ma[31:2];
      dm_be    = cmd_st_ma ? f_st_be(ldst_code_ma, rd_data_ma[1:0]) : 4'b1111;
      dm_wdata = cmd_st_ma ? f_st_data(ldst_code_ma, st_data_ma) : 32'd0;
    end
  end

  // Next-state: park in DONE only when a completed access is blocked by an outside stall
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          if (dm_ack) w_next = stall ? S_DONE : S_IDLE;
          else        w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dm_ack | w_timeout) w_next = (stall & ~w_squash) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (~stall | rst_pipe) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Watchdog counts WAIT cycles; squash flag remembers a flush that arrived mid-transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog   <= '0;
      r_squash <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;
      if (w_issue)                                 r_squash <= 1'b0;
      else if ((r_state == S_WAIT) && rst_pipe)    r_squash <= 1'b1;
    end
  end

  // Latch the request so the bus sees stable values whatever happens upstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr   <= 30'd0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_ld    <= 1'b0;
      r_code  <= 3'd0;
      r_lo    <= 2'd0;
    end else if (w_issue) begin
      r_adr   <= dm_adr;
      r_we    <= dm_we;
      r_be    <= dm_be;
      r_wdata <= dm_wdata;
      r_ld    <= cmd_ld_ma;
      r_code  <= ldst_code_ma;
      r_lo    <= rd_data_ma[1:0];
    end
  end

  // Capture formatted load data when entering DONE, since dm_rdata is only valid with ack
  always_ff @(posedge clk) begin
    if (rst)                                        r_cap <= 32'd0;
    else if ((r_state != S_DONE) && (w_next == S_DONE)) r_cap <= w_ld_now;
  end

  // MA->WB and WB->WB2 history; flush clears the write enables ahead of any stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_adr_wb  <= 5'd0;
      r_data_wb    <= 32'd0;
      r_en_wb      <= 1'b0;
      r_rd_adr_wb2 <= 5'd0;
      r_data_wb2   <= 32'd0;
      r_en_wb2     <= 1'b0;
    end else if (rst_pipe) begin
      r_en_wb  <= 1'b0;
      r_en_wb2 <= 1'b0;
    end else if (w_adv) begin
      r_rd_adr_wb2 <= r_rd_adr_wb;
      r_data_wb2   <= r_data_wb;
      r_en_wb2     <= r_en_wb;
      r_rd_adr_wb  <= rd_adr_ma;
      r_data_wb    <= w_wb_data;
      r_en_wb      <= wbk_rd_reg_ma & ~w_misalign & ~w_drop;
    end
  end

endmodule

// File: tb/tb_ma_stage.sv
// tb/tb_ma_stage.sv - self-checking bench for ma_stage with directed and random load/store traffic
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst, stall, rst_pipe, cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        dm_req, dm_we, dm_ack;
  logic [29:0] dm_adr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dc_stall, ma_misalign, ma_bus_err;
  logic [4:0]  rd_adr_wb, rd_adr_wb2;
  logic [31:0] wbk_data_wb, wbk_data_wb2;
  logic        wbk_rd_reg_wb, wbk_rd_reg_wb2;

  int errors = 0;
  int checks = 0;

  // expected WB / WB2 contents; dv=0 means adr/data are not checked
  logic [4:0]  e_adr, e_adr2;
  logic [31:0] e_data, e_data2;
  logic        e_en, e_en2;
  bit          e_dv, e_dv2;

  int          n_st, n_err, kind;
  bit          fin;
  logic [31:0] ra;
  logic [2:0]  rcode;
  logic [2:0]  codes [5];

  ma_stage #(.WDOG_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .rst_pipe(rst_pipe),
    .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .rd_adr_ma(rd_adr_ma),
    .rd_data_ma(rd_data_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma), .st_data_ma(st_data_ma),
    .ldst_code_ma(ldst_code_ma), .dm_req(dm_req), .dm_we(dm_we), .dm_adr(dm_adr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .dc_stall(dc_stall), .ma_misalign(ma_misalign), .ma_bus_err(ma_bus_err),
    .rd_adr_wb(rd_adr_wb), .wbk_data_wb(wbk_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .rd_adr_wb2(rd_adr_wb2), .wbk_data_wb2(wbk_data_wb2), .wbk_rd_reg_wb2(wbk_rd_reg_wb2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] code);
    if (code == 3'd0 || code == 3'd4) return 1;
    if (code == 3'd1 || code == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input bit mem, input logic [2:0] code, input logic [31:0] a);
    return mem && ((a % m_size(code)) != 0);
  endfunction

  function automatic logic [31:0] m_be(input bit ld, input logic [2:0] code, input logic [31:0] a);
    if (ld) return 32'hF;
    return ((32'd1 << m_size(code)) - 32'd1) << (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] code, input logic [31:0] d);
    if (m_size(code) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (m_size(code) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] code, input logic [31:0] a,
                                         input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * (a % 4));
    case (code)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic wb_shift(input logic [4:0] a, input logic [31:0] d, input logic en, input bit dv);
    e_adr2 = e_adr; e_data2 = e_data; e_en2 = e_en; e_dv2 = e_dv;
    e_adr = a; e_data = d; e_en = en; e_dv = dv;
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "_en"}, wbk_rd_reg_wb, e_en);
    chk({tag, "_en2"}, wbk_rd_reg_wb2, e_en2);
    if (e_dv) begin
      chk({tag, "_adr"}, rd_adr_wb, e_adr);
      chk({tag, "_data"}, wbk_data_wb, e_data);
    end
    if (e_dv2) begin
      chk({tag, "_adr2"}, rd_adr_wb2, e_adr2);
      chk({tag, "_data2"}, wbk_data_wb2, e_data2);
    end
  endtask

  // one instruction through MA; memory answers after 'waits' cycles, outside stall holds 'hold' cycles
  task automatic run_op(input bit ld, input bit st, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata, input logic [4:0] rd,
                        input bit en, input int waits, input int hold);
    bit mem, mis;
    mem = ld | st;
    mis = m_mis(mem, code, a);
    cmd_ld_ma = ld; cmd_st_ma = st; ldst_code_ma = code; rd_data_ma = a; st_data_ma = sd;
    rd_adr_ma = rd; wbk_rd_reg_ma = en; stall = 1'b0; dm_ack = 1'b0;
    if (!mem || mis) begin
      @(negedge clk); #1;
      chk("noreq", dm_req, 1'b0);
      chk("misalign", ma_misalign, mis);
      chk("nodcst", dc_stall, 1'b0);
      @(posedge clk); #1;
      wb_shift(rd, a, en & !mis, !(mis && ld));
    end else begin
      for (int c = 0; c <= waits; c++) begin
        @(negedge clk);
        if (c == waits) begin
          dm_ack = 1'b1; dm_rdata = rdata; stall = (hold > 0);
        end
        #1;
        chk("req", dm_req, 1'b1);
        chk("adr", dm_adr, a >> 2);
        chk("we", dm_we, st);
        chk("be", dm_be, m_be(ld, code, a));
        if (st) chk("wdata", dm_wdata, m_wdata(code, sd));
        chk("dcst", dc_stall, (c < waits));
        chk("buserr", ma_bus_err, 1'b0);
        @(posedge clk); #1;
        dm_ack = 1'b0; dm_rdata = $urandom;
      end
      if (hold > 0) chk_wb("ackhold");
      for (int h = 1; h <= hold; h++) begin
        stall = (h < hold);
        @(negedge clk); #1;
        chk("done_noreq", dm_req, 1'b0);
        chk("done_dcst", dc_stall, 1'b0);
        @(posedge clk); #1;
        if (h < hold) chk_wb("hold");
      end
      stall = 1'b0;
      wb_shift(rd, ld ? m_load(code, a, rdata) : a, en, 1'b1);
    end
    chk_wb("wb");
  endtask

  initial begin
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1; stall = 1'b0; rst_pipe = 1'b0; cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0;
    rd_adr_ma = 5'd0; rd_data_ma = 32'd0; wbk_rd_reg_ma = 1'b0; st_data_ma = 32'd0;
    ldst_code_ma = 3'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
    e_adr = 5'd0; e_adr2 = 5'd0; e_data = 32'd0; e_data2 = 32'd0;
    e_en = 1'b0; e_en2 = 1'b0; e_dv = 1'b1; e_dv2 = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_req", dm_req, 1'b0);
    chk("rst_be", dm_be, 4'd0);
    chk("rst_dcst", dc_stall, 1'b0);
    chk("rst_buserr", ma_bus_err, 1'b0);
    chk("rst_mis", ma_misalign, 1'b0);
    chk_wb("rst");
    @(posedge clk); #1;

    run_op(1, 0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 5'd1, 1, 0, 0);
    chk("lw_data", wbk_data_wb, 32'hDEADBEEF);
    run_op(1, 0, 3'd0, 32'h103, 32'd0, 32'h80112233, 5'd2, 1, 3, 0);
    chk("lb_data", wbk_data_wb, 32'hFFFFFF80);
    run_op(1, 0, 3'd4, 32'h103, 32'd0, 32'h80112233, 5'd3, 1, 3, 0);
    chk("lbu_data", wbk_data_wb, 32'h00000080);
    run_op(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 32'd0, 5'd4, 0, 0, 0);
    run_op(1, 0, 3'd2, 32'h101, 32'd0, 32'd0, 5'd5, 1, 0, 0);
    run_op(0, 0, 3'd0, 32'h5555AAAA, 32'd0, 32'd0, 5'd6, 1, 0, 0);
    run_op(1, 0, 3'd1, 32'h102, 32'd0, 32'h8001_7FFF, 5'd11, 1, 0, 2);
    run_op(1, 0, 3'd5, 32'h106, 32'd0, 32'h8001_7FFF, 5'd12, 1, 2, 2);
    run_op(0, 1, 3'd0, 32'h301, 32'hCAFE_F00D, 32'd0, 5'd0, 0, 1, 1);

    // flush while the bus is waiting
    run_op(0, 0, 3'd0, 32'h0000_0009, 32'd0, 32'd0, 5'd9, 1, 0, 0);
    run_op(0, 0, 3'd0, 32'h0000_000A, 32'd0, 32'd0, 5'd10, 1, 0, 0);
    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = 3'd2; rd_data_ma = 32'h300;
    rd_adr_ma = 5'd7; wbk_rd_reg_ma = 1'b1; stall = 1'b0; dm_ack = 1'b0;
    @(negedge clk); #1;
    chk("rp_req0", dm_req, 1'b1);
    chk("rp_dcst0", dc_stall, 1'b1);
    @(posedge clk); #1;
    rst_pipe = 1'b1;
    @(negedge clk); #1;
    chk("rp_req1", dm_req, 1'b1);
    chk("rp_dcst1", dc_stall, 1'b1);
    @(posedge clk); #1;
    rst_pipe = 1'b0;
    chk("rp_clr_wb", wbk_rd_reg_wb, 1'b0);
    chk("rp_clr_wb2", wbk_rd_reg_wb2, 1'b0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rp_req_hold", dm_req, 1'b1);
      chk("rp_dcst_hold", dc_stall, 1'b1);
      chk("rp_adr_hold", dm_adr, 32'h300 >> 2);
      @(posedge clk); #1;
    end
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 32'h1234_5678;
    #1;
    chk("rp_ack_req", dm_req, 1'b1);
    chk("rp_ack_dcst", dc_stall, 1'b0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("rp_nowb", wbk_rd_reg_wb, 1'b0);
    e_en = 1'b0; e_en2 = 1'b0; e_dv = 1'b0; e_dv2 = 1'b0;
    run_op(0, 0, 3'd0, 32'h0000_0ABC, 32'd0, 32'd0, 5'd13, 1, 0, 0);

    // bus never answers: watchdog ends the access with zero data
    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; ldst_code_ma = 3'd2; rd_data_ma = 32'h400;
    rd_adr_ma = 5'd8; wbk_rd_reg_ma = 1'b1; stall = 1'b0; dm_ack = 1'b0;
    n_st = 0; n_err = 0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk); #1;
      if (ma_bus_err) n_err++;
      if (dc_stall) n_st++;
      else          fin = 1'b1;
      @(posedge clk); #1;
    end
    chk("to_finished", fin, 1'b1);
    chk("to_stall_cycles", n_st, 255);
    chk("to_err_pulses", n_err, 1);
    wb_shift(5'd8, 32'd0, 1'b1, 1'b1);
    chk_wb("to");

    for (int i = 0; i < 50; i++) begin
      kind = $urandom_range(0, 2);
      ra = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 0) ra = ra & 32'hFFFF_FFFC;
      rcode = (kind == 2) ? codes[$urandom_range(0, 2)] : codes[$urandom_range(0, 4)];
      run_op(kind == 1, kind == 2, rcode, ra, $urandom, $urandom, 5'($urandom_range(1, 31)),
             kind != 2, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; wbk_rd_reg_ma = 1'b0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
